// File: rtl/mar_mdr_mem_ctrl_if.sv
// ----------------------------------------------------------------------------
// mar_mdr_mem_ctrl_if
//   Groups the datapath-side load controls, the CPU memory handshake, the SRAM
//   pins and the board I/O used by mar_mdr_mem_ctrl.
//   master : the environment (bus module, control FSM, SRAM and board)
//   slave  : the controller itself
//   Signals:
//     bus_in[15:0]     datapath bus value to load into MAR/MDR
//     ld_mar, ld_mdr   register load strobes
//     mio_en           1: MDR loads from memory/I/O reads, 0: from bus_in
//     mem_req, mem_rw  access request and direction (1 = write)
//     mem_ready        one-cycle completion pulse
//     mar_out, mdr_out register values back to the bus module
//     mem_addr, mem_wdata, mem_rdata, mem_ce_n, mem_oe_n, mem_we_n  SRAM pins
//     switches         board switches, read at the I/O address
//     hex_out          hex display register, written at the I/O address
// ----------------------------------------------------------------------------
interface mar_mdr_mem_ctrl_if;
   logic [15:0] bus_in;
   logic        ld_mar;
   logic        ld_mdr;
   logic        mio_en;
   logic        mem_req;
   logic        mem_rw;
   logic        mem_ready;
   logic [15:0] mar_out;
   logic [15:0] mdr_out;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ce_n;
   logic        mem_oe_n;
   logic        mem_we_n;
   logic [15:0] switches;
   logic [15:0] hex_out;

   modport master (
      output bus_in, ld_mar, ld_mdr, mio_en, mem_req, mem_rw, mem_rdata, switches,
      input  mem_ready, mar_out, mdr_out, mem_addr, mem_wdata, mem_ce_n, mem_oe_n, mem_we_n,
             hex_out
   );

   modport slave (
      input  bus_in, ld_mar, ld_mdr, mio_en, mem_req, mem_rw, mem_rdata, switches,
      output mem_ready, mar_out, mdr_out, mem_addr, mem_wdata, mem_ce_n, mem_oe_n, mem_we_n,
             hex_out
   );
endinterface

// File: rtl/mar_mdr_mem_ctrl.sv
// ----------------------------------------------------------------------------
// mar_mdr_mem_ctrl
//   MAR/MDR load side of the datapath bus, multi-cycle SRAM handshake and
//   memory-mapped I/O decode (switches read / hex display written at IO_ADDR).
//   Ports:
//     i_clk    system clock, rising edge
//     i_rst_n  asynchronous active-low reset
//     bus      mar_mdr_mem_ctrl_if.slave, see interface file for signal list
//   Parameters:
//     WAIT_CYCLES  SRAM access-state length in cycles (>= 1)
//     IO_ADDR      address decoded as I/O
// ----------------------------------------------------------------------------
module mar_mdr_mem_ctrl #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
   input logic               i_clk,
   input logic               i_rst_n,
   mar_mdr_mem_ctrl_if.slave bus
);

   localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e          r_state;
   logic [CntW-1:0] r_cnt;
   logic            r_rw;
   logic            r_io_hit;
   logic [15:0]     r_mar;
   logic [15:0]     r_mdr;
   logic [15:0]     r_hex;
   logic            r_ready;
   logic            r_ce_n;
   logic            r_oe_n;
   logic            r_we_n;

   logic            w_io_hit;

   // Decode uses the MAR value held before the request edge.
   assign w_io_hit = (r_mar == IO_ADDR);

   // Strobes are set from the next state so they are clean flop outputs that are
   // asserted for exactly the ACCESS cycles; the async reset forces them high at once.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= StIdle;
         r_cnt    <= '0;
         r_rw     <= 1'b0;
         r_io_hit <= 1'b0;
         r_mar    <= '0;
         r_mdr    <= '0;
         r_hex    <= '0;
         r_ready  <= 1'b0;
         r_ce_n   <= 1'b1;
         r_oe_n   <= 1'b1;
         r_we_n   <= 1'b1;
      end else begin
         r_ready <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (bus.mem_req) begin
                  // A request edge blocks both register loads.
                  r_state  <= StAccess;
                  r_rw     <= bus.mem_rw;
                  r_io_hit <= w_io_hit;
                  r_cnt    <= w_io_hit ? '0 : CntLoad;
                  r_ce_n   <= w_io_hit;
                  r_oe_n   <= w_io_hit | bus.mem_rw;
                  r_we_n   <= w_io_hit | ~bus.mem_rw;
               end else begin
                  if (bus.ld_mar) begin
                     r_mar <= bus.bus_in;
                  end
                  if (bus.ld_mdr && !bus.mio_en) begin
                     r_mdr <= bus.bus_in;
                  end
               end
            end
            StAccess: begin
               if (r_cnt == '0) begin
                  if (!r_rw) begin
                     r_mdr <= r_io_hit ? bus.switches : bus.mem_rdata;
                  end else if (r_io_hit) begin
                     r_hex <= r_mdr;
                  end
                  r_state <= StDone;
                  r_ready <= 1'b1;
                  r_ce_n  <= 1'b1;
                  r_oe_n  <= 1'b1;
                  r_we_n  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            StDone: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign bus.mem_ready = r_ready;
   assign bus.mar_out   = r_mar;
   assign bus.mdr_out   = r_mdr;
   assign bus.mem_addr  = r_mar;
   assign bus.mem_wdata = r_mdr;
   assign bus.mem_ce_n  = r_ce_n;
   assign bus.mem_oe_n  = r_oe_n;
   assign bus.mem_we_n  = r_we_n;
   assign bus.hex_out   = r_hex;

endmodule

// File: tb/tb_mar_mdr_mem_ctrl.sv
module tb_mar_mdr_mem_ctrl;
   localparam int unsigned W  = 2;
   localparam logic [15:0] IO = 16'hFFFF;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mar_mdr_mem_ctrl_if bus_a ();
   mar_mdr_mem_ctrl_if bus_b ();

   mar_mdr_mem_ctrl #(.WAIT_CYCLES(W), .IO_ADDR(IO)) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_a)
   );

   mar_mdr_mem_ctrl #(.WAIT_CYCLES(4), .IO_ADDR(IO)) u_dut4 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 100) $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model (dut with W=2) ----------------
   // An accepted request at cycle k owns cycles k+1..m_end (access) and m_end+1 (done).
   int unsigned m_cyc;
   int unsigned m_end;
   logic        m_busy, m_rw, m_io;
   logic [15:0] m_mar, m_mdr, m_hex;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc  <= 0;
         m_end  <= 0;
         m_busy <= 1'b0;
         m_rw   <= 1'b0;
         m_io   <= 1'b0;
         m_mar  <= '0;
         m_mdr  <= '0;
         m_hex  <= '0;
      end else begin
         m_cyc <= m_cyc + 1;
         if (!m_busy) begin
            if (bus_a.mem_req) begin
               m_busy <= 1'b1;
               m_rw   <= bus_a.mem_rw;
               m_io   <= (m_mar == IO);
               m_end  <= m_cyc + ((m_mar == IO) ? 1 : W);
            end else begin
               if (bus_a.ld_mar) m_mar <= bus_a.bus_in;
               if (bus_a.ld_mdr && !bus_a.mio_en) m_mdr <= bus_a.bus_in;
            end
         end else if (m_cyc == m_end) begin
            if (!m_rw) m_mdr <= m_io ? bus_a.switches : bus_a.mem_rdata;
            else if (m_io) m_hex <= m_mdr;
         end else if (m_cyc == m_end + 1) begin
            m_busy <= 1'b0;
         end
      end
   end

   logic e_access, e_ready;
   always_comb begin
      e_access = m_busy && (m_cyc <= m_end) && !m_io;
      e_ready  = m_busy && (m_cyc == m_end + 1);
   end

   always @(negedge clk) begin
      check("mar", bus_a.mar_out, m_mar);
      check("mdr", bus_a.mdr_out, m_mdr);
      check("hex", bus_a.hex_out, m_hex);
      check("addr", bus_a.mem_addr, m_mar);
      check("wdata", bus_a.mem_wdata, m_mdr);
      check("ready", 16'(bus_a.mem_ready), 16'(e_ready));
      check("ce_n", 16'(bus_a.mem_ce_n), 16'(!e_access));
      check("oe_n", 16'(bus_a.mem_oe_n), 16'(!(e_access && !m_rw)));
      check("we_n", 16'(bus_a.mem_we_n), 16'(!(e_access && m_rw)));
   end

   // ---------------- stimulus ----------------
   task automatic idle_a();
      bus_a.ld_mar  = 1'b0;
      bus_a.ld_mdr  = 1'b0;
      bus_a.mio_en  = 1'b0;
      bus_a.mem_req = 1'b0;
      bus_a.mem_rw  = 1'b0;
   endtask

   task automatic load_mar(input logic [15:0] v);
      @(negedge clk);
      idle_a();
      bus_a.bus_in = v;
      bus_a.ld_mar = 1'b1;
   endtask

   task automatic load_mdr(input logic [15:0] v);
      @(negedge clk);
      idle_a();
      bus_a.bus_in = v;
      bus_a.ld_mdr = 1'b1;
   endtask

   task automatic request(input logic rw);
      @(negedge clk);
      idle_a();
      bus_a.mem_req = 1'b1;
      bus_a.mem_rw  = rw;
   endtask

   int pulses;
   int n;
   int n2;

   initial begin
      rst_n = 1'b0;
      bus_a.bus_in = '0; bus_a.mem_rdata = '0; bus_a.switches = '0;
      idle_a();
      bus_b.bus_in = '0; bus_b.mem_rdata = '0; bus_b.switches = '0;
      bus_b.ld_mar = 1'b0; bus_b.ld_mdr = 1'b0; bus_b.mio_en = 1'b0;
      bus_b.mem_req = 1'b0; bus_b.mem_rw = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_mar", bus_a.mar_out, 16'h0000);
      check("rst_strobes", {13'd0, bus_a.mem_ce_n, bus_a.mem_oe_n, bus_a.mem_we_n}, 16'h0007);
      check("rst_ready", 16'(bus_a.mem_ready), 16'h0000);
      rst_n = 1'b1;

      // SRAM read at 0040
      load_mar(16'h0040);
      request(1'b0);
      bus_a.mem_rdata = 16'hBEEF;
      @(negedge clk); idle_a();
      check("rd_ce_c1", 16'(bus_a.mem_ce_n), 16'h0000);
      check("rd_oe_c1", 16'(bus_a.mem_oe_n), 16'h0000);
      @(negedge clk);
      check("rd_oe_c2", 16'(bus_a.mem_oe_n), 16'h0000);
      check("rd_ready_c2", 16'(bus_a.mem_ready), 16'h0000);
      @(negedge clk);
      check("rd_ready_c3", 16'(bus_a.mem_ready), 16'h0001);
      check("rd_mdr", bus_a.mdr_out, 16'hBEEF);

      // SRAM write 1234 at 0041
      load_mar(16'h0041);
      load_mdr(16'h1234);
      request(1'b1);
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk); idle_a();
         check("wr_we", 16'(bus_a.mem_we_n), 16'h0000);
         check("wr_oe", 16'(bus_a.mem_oe_n), 16'h0001);
         check("wr_addr", bus_a.mem_addr, 16'h0041);
         check("wr_wdata", bus_a.mem_wdata, 16'h1234);
      end
      @(negedge clk);
      check("wr_ready", 16'(bus_a.mem_ready), 16'h0001);
      check("wr_hex", bus_a.hex_out, 16'h0000);

      // I/O read of switches
      load_mar(16'hFFFF);
      bus_a.switches = 16'h00A5;
      request(1'b0);
      @(negedge clk); idle_a();
      check("io_rd_strobes", {13'd0, bus_a.mem_ce_n, bus_a.mem_oe_n, bus_a.mem_we_n}, 16'h0007);
      @(negedge clk);
      check("io_rd_ready", 16'(bus_a.mem_ready), 16'h0001);
      check("io_rd_mdr", bus_a.mdr_out, 16'h00A5);

      // I/O write to hex display
      load_mdr(16'h5A5A);
      request(1'b1);
      @(negedge clk); idle_a();
      check("io_wr_strobes", {13'd0, bus_a.mem_ce_n, bus_a.mem_oe_n, bus_a.mem_we_n}, 16'h0007);
      @(negedge clk);
      check("io_wr_ready", 16'(bus_a.mem_ready), 16'h0001);
      check("io_wr_hex", bus_a.hex_out, 16'h5A5A);

      // LD_MAR on the request edge is ignored
      load_mar(16'h0040);
      request(1'b0);
      bus_a.ld_mar = 1'b1;
      bus_a.bus_in = 16'h0100;
      bus_a.mem_rdata = 16'h1111;
      @(negedge clk); idle_a();
      check("same_edge_addr", bus_a.mem_addr, 16'h0040);
      repeat (2) @(negedge clk);
      check("same_edge_mdr", bus_a.mdr_out, 16'h1111);
      check("same_edge_mar", bus_a.mar_out, 16'h0040);

      // LD_MAR and Mem_Req while busy are ignored
      request(1'b0);
      bus_a.mem_rdata = 16'h2222;
      pulses = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (bus_a.mem_ready) pulses++;
         if (i == 1) begin
            bus_a.ld_mar = 1'b1;
            bus_a.bus_in = 16'h0200;
         end
         if (i == 4) idle_a();
      end
      check("busy_pulses", 16'(pulses), 16'h0001);
      check("busy_mar", bus_a.mar_out, 16'h0040);

      // Reset in the middle of a write access
      request(1'b1);
      @(negedge clk); idle_a();
      check("rst_mid_we_before", 16'(bus_a.mem_we_n), 16'h0000);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_strobes", {13'd0, bus_a.mem_ce_n, bus_a.mem_oe_n, bus_a.mem_we_n}, 16'h0007);
      check("rst_mid_mar", bus_a.mar_out, 16'h0000);
      check("rst_mid_mdr", bus_a.mdr_out, 16'h0000);
      check("rst_mid_hex", bus_a.hex_out, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus_a.mem_ready) pulses++;
      end
      check("rst_mid_no_ready", 16'(pulses), 16'h0000);

      // WAIT_CYCLES=4 instance, reads issued back-to-back by holding Mem_Req.
      // MAR cannot change between back-to-back requests, so both read address 0000.
      @(negedge clk);
      bus_b.mem_req = 1'b1;
      bus_b.mem_rdata = 16'h0C0C;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         n = i;
         if (bus_b.mem_ready) break;
      end
      check("w4_req_to_pulse", 16'(n), 16'h0005);
      check("w4_addr", bus_b.mem_addr, 16'h0000);
      check("w4_mdr", bus_b.mdr_out, 16'h0C0C);
      n2 = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         n2 = i;
         if (bus_b.mem_ready) break;
      end
      check("w4_pulse_spacing", 16'(n2), 16'h0006);
      bus_b.mem_req = 1'b0;

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         bus_a.bus_in    = ($urandom_range(0, 3) == 0) ? IO : 16'($urandom);
         bus_a.ld_mar    = ($urandom_range(0, 3) == 0);
         bus_a.ld_mdr    = ($urandom_range(0, 2) == 0);
         bus_a.mio_en    = 1'($urandom);
         bus_a.mem_req   = ($urandom_range(0, 2) == 0);
         bus_a.mem_rw    = 1'($urandom);
         bus_a.mem_rdata = 16'($urandom);
         bus_a.switches  = 16'($urandom);
      end
      @(negedge clk);
      idle_a();
      repeat (8) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
